step_pulse_gen: RTL and testbench

//   Conditions the raw STEP push button into clean single-cycle step pulses.

---
 rtl/step_pulse_gen.sv | 122 ++++++++++++
 tb/tb_step_pulse_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// STEP button conditioner: 2-flop sync -> counter debounce -> press/auto-repeat FSM.
// Pulse lags the press by DEBOUNCE_CYCLES+3 edges; there is no backpressure, so each pulse is a one-cycle enable.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  output logic       stepPulse,
  output logic       stepHeld,
  output logic [7:0] pulseCount
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int RDW = $clog2(REPEAT_DELAY);
  localparam int RPW = $clog2(REPEAT_PERIOD);
  localparam int RW  = (RDW > RPW) ? RDW : RPW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_t        state_q, state_d;
  logic [RW-1:0] rtimer_q, rtimer_d;
  logic          pulse_q, pulse_d;
  logic [7:0]    cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (s2_q != stable_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // The FSM reads the registered stable level, so a release that lands on the
  // same edge as a repeat expiry is seen one edge later and cannot pulse.
  always_comb begin
    state_d  = state_q;
    rtimer_d = rtimer_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable_q) begin
          state_d  = PRESSED;
          pulse_d  = 1'b1;
          rtimer_d = '0;
        end
      end
      PRESSED: begin
        if (!stable_q) begin
          state_d = IDLE;
        end else if (REPEAT_EN && (rtimer_q == RW'(REPEAT_DELAY - 1))) begin
          state_d  = REPEAT;
          pulse_d  = 1'b1;
          rtimer_d = '0;
        end else begin
          rtimer_d = rtimer_q + RW'(1);
        end
      end
      REPEAT: begin
        if (!stable_q) begin
          state_d = IDLE;
        end else if (rtimer_q == RW'(REPEAT_PERIOD - 1)) begin
          pulse_d  = 1'b1;
          rtimer_d = '0;
        end else begin
          rtimer_d = rtimer_q + RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pulse_d) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      state_q  <= IDLE;
      rtimer_q <= '0;
      pulse_q  <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      s1_q     <= step;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      rtimer_q <= rtimer_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stepPulse  = pulse_q;
  assign stepHeld   = stable_q;
  assign pulseCount = cnt_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: one instance without and one with auto-repeat,
// expected pulses and output snapshots queued by stimulus, compared by a monitor.
module tb_step_pulse_gen;

  logic       clock;
  logic       reset;
  logic       step0, step1;
  logic       pulse0, pulse1;
  logic       held0, held1;
  logic [7:0] cnt0, cnt1;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut0 (
    .clock(clock), .reset(reset), .step(step0),
    .stepPulse(pulse0), .stepHeld(held0), .pulseCount(cnt0)
  );

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut1 (
    .clock(clock), .reset(reset), .step(step1),
    .stepPulse(pulse1), .stepHeld(held1), .pulseCount(cnt1)
  );

  typedef struct {
    int         cyc;
    int         inst;
    logic [7:0] cnt;
  } pexp_t;

  typedef struct {
    int         cyc;
    int         inst;
    logic       held;
    logic [7:0] cnt;
  } sexp_t;

  pexp_t      pq[$];
  sexp_t      sq[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       done = 1'b0;
  logic [7:0] exp_cnt0 = 8'd0;
  logic [7:0] exp_cnt1 = 8'd0;
  sexp_t      s_cur;
  pexp_t      p_cur;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0d required=%0d", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic chk_pulse(input int inst, input logic pulse, input logic [7:0] cnt);
    if (pulse) begin
      if (pq.size() > 0 && pq[0].cyc == cyc && pq[0].inst == inst) begin
        p_cur = pq.pop_front();
        chk("pulse_count", inst, int'(cnt), int'(p_cur.cnt));
      end else begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse inst=%0d cyc=%0d actual=1 required=0", inst, cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s_cur = sq.pop_front();
      if (s_cur.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL snap_missed inst=%0d cyc=%0d actual=late required=%0d", s_cur.inst, cyc, s_cur.cyc);
      end else begin
        chk("stepHeld", s_cur.inst, int'(s_cur.inst == 0 ? held0 : held1), int'(s_cur.held));
        chk("pulseCount", s_cur.inst, int'(s_cur.inst == 0 ? cnt0 : cnt1), int'(s_cur.cnt));
      end
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      p_cur = pq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse inst=%0d cyc=%0d actual=0 required=1", p_cur.inst, p_cur.cyc);
    end
    chk_pulse(0, pulse0, cnt0);
    chk_pulse(1, pulse1, cnt1);
    if (done) begin
      while (pq.size() > 0) begin
        p_cur = pq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_pulse inst=%0d cyc=%0d actual=0 required=1", p_cur.inst, p_cur.cyc);
      end
      while (sq.size() > 0) begin
        s_cur = sq.pop_front();
        checks++;
        failures++;
        $display("FAIL snap_unchecked inst=%0d cyc=%0d actual=none required=%0d", s_cur.inst, cyc, s_cur.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic snap(input int c, input int inst, input logic held, input logic [7:0] cnt);
    sexp_t s;
    s.cyc  = c;
    s.inst = inst;
    s.held = held;
    s.cnt  = cnt;
    sq.push_back(s);
  endtask

  task automatic exp_pulse(input int inst, input int c);
    pexp_t p;
    if (inst == 0) begin
      exp_cnt0 = exp_cnt0 + 8'd1;
      p.cnt    = exp_cnt0;
    end else begin
      exp_cnt1 = exp_cnt1 + 8'd1;
      p.cnt    = exp_cnt1;
    end
    p.cyc  = c;
    p.inst = inst;
    pq.push_back(p);
  endtask

  task automatic do_reset();
    int c;
    c     = cyc;
    reset = 1'b0;
    step0 = 1'b0;
    step1 = 1'b0;
    exp_cnt0 = 8'd0;
    exp_cnt1 = 8'd0;
    snap(c + 1, 0, 1'b0, 8'd0);
    snap(c + 1, 1, 1'b0, 8'd0);
    tick(3);
    reset = 1'b1;
    tick(2);
  endtask

  // Press dut0 at this negedge (c0) for 'hold' cycles: stepHeld at c0+6,
  // pulse at c0+7, stepHeld falls 6 cycles after release.
  task automatic press(input int hold);
    int c0, c1;
    c0    = cyc;
    step0 = 1'b1;
    snap(c0 + 5, 0, 1'b0, exp_cnt0);
    snap(c0 + 6, 0, 1'b1, exp_cnt0);
    exp_pulse(0, c0 + 7);
    snap(c0 + 7, 0, 1'b1, exp_cnt0);
    tick(hold);
    c1    = cyc;
    step0 = 1'b0;
    snap(c1 + 5, 0, 1'b1, exp_cnt0);
    snap(c1 + 6, 0, 1'b0, exp_cnt0);
    tick(10);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0, c2;
    reset = 1'b1;
    step0 = 1'b1;
    step1 = 1'b0;
    #1 reset = 1'b0;

    // 1: held through reset, then one pulse after full latency
    for (int k = 1; k <= 4; k++) begin
      snap(k, 0, 1'b0, 8'd0);
      snap(k, 1, 1'b0, 8'd0);
    end
    tick(4);
    reset = 1'b1;
    press(10);

    // 2: clean 20-cycle press, no repeat
    do_reset();
    press(20);

    // 3: bounce 1,0,1,0 every 2 cycles then hold
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step0 = (i % 2 == 0);
      snap(cyc + 1, 0, 1'b0, 8'd0);
      snap(cyc + 2, 0, 1'b0, 8'd0);
      tick(2);
    end
    press(12);

    // 4: 3-cycle glitch is dropped
    do_reset();
    c0 = cyc;
    for (int k = 1; k <= 12; k++) snap(c0 + k, 0, 1'b0, 8'd0);
    step0 = 1'b1;
    tick(3);
    step0 = 1'b0;
    tick(12);

    // 5: auto-repeat, release 30 cycles after stepHeld rises
    do_reset();
    c0    = cyc;
    step1 = 1'b1;
    snap(c0 + 5, 1, 1'b0, 8'd0);
    snap(c0 + 6, 1, 1'b1, 8'd0);
    exp_pulse(1, c0 + 7);
    for (int t = c0 + 15; t <= c0 + 42; t += 3) exp_pulse(1, t);
    tick(36);
    step1 = 1'b0;
    snap(c0 + 41, 1, 1'b1, 8'd10);
    snap(c0 + 42, 1, 1'b0, 8'd11);
    snap(c0 + 52, 1, 1'b0, 8'd11);
    tick(20);

    // 5b: release lands on a repeat expiry -> no pulse
    do_reset();
    c0    = cyc;
    step1 = 1'b1;
    exp_pulse(1, c0 + 7);
    for (int t = c0 + 15; t <= c0 + 39; t += 3) exp_pulse(1, t);
    tick(35);
    step1 = 1'b0;
    snap(c0 + 40, 1, 1'b1, 8'd10);
    snap(c0 + 41, 1, 1'b0, 8'd10);
    snap(c0 + 50, 1, 1'b0, 8'd10);
    tick(20);

    // 6: 256 presses wrap pulseCount to 0, then reset mid-PRESSED
    do_reset();
    repeat (256) press(8);
    snap(cyc + 1, 0, 1'b0, 8'd0);
    tick(2);
    c0    = cyc;
    step0 = 1'b1;
    exp_pulse(0, c0 + 7);
    snap(c0 + 8, 0, 1'b1, 8'd1);
    tick(9);
    #7;
    reset = 1'b0;
    exp_cnt0 = 8'd0;
    snap(cyc, 0, 1'b0, 8'd0);
    snap(cyc, 1, 1'b0, 8'd0);
    @(negedge clock);
    tick(2);
    c2    = cyc;
    reset = 1'b1;
    snap(c2 + 5, 0, 1'b0, 8'd0);
    snap(c2 + 6, 0, 1'b1, 8'd0);
    exp_pulse(0, c2 + 7);
    snap(c2 + 7, 0, 1'b1, 8'd1);
    tick(12);
    step0 = 1'b0;
    tick(10);
    done = 1'b1;
  end

endmodule
